// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between loads and store-buffer drain; grant and memory drive are combinational, load data returns 1 cycle later.
// Losers see ready low and hold their request; NORMAL favours loads, URGENT/DRAIN favour stores, a starved store is forced through.
module mem_port_arbiter #(
    parameter int HIGH_WATER   = 6,
    parameter int LOW_WATER    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        ld_req_valid,
    input  logic [15:0] ld_req_addr,
    output logic        ld_req_ready,
    output logic        ld_resp_valid,
    output logic [15:0] ld_resp_data,
    input  logic        st_valid,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    output logic        st_ready,
    input  logic [3:0]  st_occupancy,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] S_NORMAL = 2'd0;
    localparam logic [1:0] S_URGENT = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    localparam logic [3:0] HI_MARK   = 4'(HIGH_WATER);
    localparam logic [3:0] LO_MARK   = 4'(LOW_WATER);
    localparam logic [2:0] STARVE_AT = 3'(STARVE_LIMIT);
    localparam logic [2:0] STARVE_MAX = 3'h7;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [2:0]  starve_cnt;
    logic [2:0]  starve_nxt;
    logic        resp_flag;
    logic        done_reg;
    logic        done_nxt;

    logic        ld_ok;
    logic        starved;
    logic        ld_gnt;
    logic        st_gnt;

    // A flush only blocks new loads; stores are committed and must still drain.
    assign ld_ok   = ld_req_valid && !flush;
    assign starved = (starve_cnt == STARVE_AT);

    always_comb begin
        ld_gnt = 1'b0;
        st_gnt = 1'b0;
        case (state)
            S_NORMAL: begin
                if (starved && st_valid) begin
                    st_gnt = 1'b1;
                end else if (ld_ok) begin
                    ld_gnt = 1'b1;
                end else if (st_valid) begin
                    st_gnt = 1'b1;
                end
            end
            S_URGENT: begin
                if (st_valid) begin
                    st_gnt = 1'b1;
                end else if (ld_ok) begin
                    ld_gnt = 1'b1;
                end
            end
            S_DRAIN: begin
                st_gnt = st_valid;
            end
            default: begin
                ld_gnt = 1'b0;
                st_gnt = 1'b0;
            end
        endcase
    end

    assign ld_req_ready = ld_gnt;
    assign st_ready     = st_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        if (st_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = st_addr;
            mem_wdata = st_data;
        end else if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = ld_req_addr;
        end
    end

    // Counter keeps running in every state but is only consulted in NORMAL.
    always_comb begin
        starve_nxt = starve_cnt;
        if (!st_valid || st_gnt) begin
            starve_nxt = 3'h0;
        end else if (ld_gnt && (starve_cnt != STARVE_MAX)) begin
            starve_nxt = starve_cnt + 3'h1;
        end
    end

    // Occupancy is sampled before any pop in the same cycle.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (drain_req && (state != S_DRAIN)) begin
            state_nxt = S_DRAIN;
        end else begin
            case (state)
                S_DRAIN: begin
                    if ((st_occupancy == 4'h0) && !st_valid) begin
                        state_nxt = S_NORMAL;
                        done_nxt  = 1'b1;
                    end
                end
                S_NORMAL: begin
                    if (st_occupancy >= HI_MARK) begin
                        state_nxt = S_URGENT;
                    end
                end
                S_URGENT: begin
                    if (st_occupancy <= LO_MARK) begin
                        state_nxt = S_NORMAL;
                    end
                end
                default: begin
                    state_nxt = S_NORMAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_NORMAL;
            starve_cnt <= 3'h0;
            resp_flag  <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            resp_flag  <= ld_gnt;
            done_reg   <= done_nxt;
        end
    end

    assign ld_resp_valid = resp_flag && !flush;
    assign ld_resp_data  = mem_rdata;
    assign drain_done    = done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; memory model returns addr ^ 16'hA5A5 one cycle after a read.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        ld_req_valid;
    logic [15:0] ld_req_addr;
    logic        ld_req_ready;
    logic        ld_resp_valid;
    logic [15:0] ld_resp_data;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic        st_ready;
    logic [3:0]  st_occupancy;
    logic        drain_req;
    logic        drain_done;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .HIGH_WATER(6),
        .LOW_WATER(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .ld_req_valid(ld_req_valid),
        .ld_req_addr(ld_req_addr),
        .ld_req_ready(ld_req_ready),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_data(ld_resp_data),
        .st_valid(st_valid),
        .st_addr(st_addr),
        .st_data(st_data),
        .st_ready(st_ready),
        .st_occupancy(st_occupancy),
        .drain_req(drain_req),
        .drain_done(drain_done),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr ^ 16'hA5A5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        ld_req_valid = 1'b0;
        st_valid     = 1'b0;
        flush        = 1'b0;
        drain_req    = 1'b0;
        st_occupancy = 4'd0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        mem_rdata    = 16'h0000;
        ld_req_addr  = 16'h0000;
        st_addr      = 16'h0000;
        st_data      = 16'h0000;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        settle();

        // reset state
        chk("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
        chk("rst_drain_done", 32'(drain_done), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_ld_ready", 32'(ld_req_ready), 32'd0);
        chk("rst_st_ready", 32'(st_ready), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);

        // back-to-back loads
        for (int i = 0; i < 3; i++) begin
            ld_req_valid = 1'b1;
            ld_req_addr  = 16'h0010 + 16'(i);
            settle();
            chk("ld_ready", 32'(ld_req_ready), 32'd1);
            chk("ld_we", 32'(mem_we), 32'd0);
            chk("ld_mem_addr", 32'(mem_addr), 32'(16'h0010 + 16'(i)));
            tick();
            chk("ld_resp_valid", 32'(ld_resp_valid), 32'd1);
            chk("ld_resp_data", 32'(ld_resp_data), 32'((16'h0010 + 16'(i)) ^ 16'hA5A5));
        end
        idle();
        tick();
        chk("ld_resp_idle", 32'(ld_resp_valid), 32'd0);

        // starvation: four loads then one forced store, repeating
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0020;
        st_valid     = 1'b1;
        st_addr      = 16'h0100;
        st_data      = 16'hBEEF;
        st_occupancy = 4'd3;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk("starve_st_ready", 32'(st_ready), (k % 5 == 4) ? 32'd1 : 32'd0);
            chk("starve_ld_ready", 32'(ld_req_ready), (k % 5 == 4) ? 32'd0 : 32'd1);
            if (k == 4) begin
                chk("starve_we", 32'(mem_we), 32'd1);
                chk("starve_addr", 32'(mem_addr), 32'h0100);
                chk("starve_wdata", 32'(mem_wdata), 32'hBEEF);
            end
            tick();
        end
        idle();
        tick();

        // watermarks
        ld_req_valid = 1'b1;
        st_valid     = 1'b1;
        st_occupancy = 4'd6;
        settle();
        chk("hw_old_state_ld", 32'(ld_req_ready), 32'd1);
        tick();
        st_occupancy = 4'd4;
        settle();
        chk("urg_st_wins", 32'(st_ready), 32'd1);
        chk("urg_ld_loses", 32'(ld_req_ready), 32'd0);
        tick();
        st_occupancy = 4'd5;
        settle();
        chk("urg_occ5_st", 32'(st_ready), 32'd1);
        tick();
        st_valid     = 1'b0;
        st_occupancy = 4'd3;
        settle();
        chk("urg_no_st_ld", 32'(ld_req_ready), 32'd1);
        tick();
        st_valid     = 1'b1;
        st_occupancy = 4'd2;
        settle();
        chk("urg_occ2_st", 32'(st_ready), 32'd1);
        tick();
        settle();
        chk("normal_back_ld", 32'(ld_req_ready), 32'd1);
        chk("normal_back_st", 32'(st_ready), 32'd0);
        tick();
        // store pop at the high-water mark still moves to URGENT
        ld_req_valid = 1'b0;
        st_occupancy = 4'd6;
        settle();
        chk("hw_pop_st", 32'(st_ready), 32'd1);
        tick();
        ld_req_valid = 1'b1;
        st_occupancy = 4'd5;
        settle();
        chk("hw_pop_urgent", 32'(st_ready), 32'd1);
        tick();
        st_occupancy = 4'd1;
        tick();
        idle();
        tick();

        // drain
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0030;
        drain_req    = 1'b1;
        st_occupancy = 4'd3;
        settle();
        chk("drain_req_cycle_ld", 32'(ld_req_ready), 32'd1);
        tick();
        drain_req = 1'b0;
        st_valid  = 1'b1;
        for (int j = 0; j < 3; j++) begin
            st_occupancy = 4'(3 - j);
            st_addr      = 16'h0200 + 16'(j);
            settle();
            chk("drain_ld_blocked", 32'(ld_req_ready), 32'd0);
            chk("drain_st_ready", 32'(st_ready), 32'd1);
            chk("drain_done_early", 32'(drain_done), 32'd0);
            tick();
        end
        st_valid     = 1'b0;
        st_occupancy = 4'd0;
        settle();
        chk("drain_empty_ld", 32'(ld_req_ready), 32'd0);
        chk("drain_empty_en", 32'(mem_en), 32'd0);
        chk("drain_done_pre", 32'(drain_done), 32'd0);
        tick();
        chk("drain_done_pulse", 32'(drain_done), 32'd1);
        chk("post_drain_ld", 32'(ld_req_ready), 32'd1);
        tick();
        chk("drain_done_drop", 32'(drain_done), 32'd0);
        idle();
        tick();

        // flush
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0040;
        st_occupancy = 4'd1;
        settle();
        chk("fl_ld_granted", 32'(ld_req_ready), 32'd1);
        tick();
        flush    = 1'b1;
        st_valid = 1'b1;
        st_addr  = 16'h0300;
        st_data  = 16'h1234;
        settle();
        chk("fl_resp_killed", 32'(ld_resp_valid), 32'd0);
        chk("fl_ld_blocked", 32'(ld_req_ready), 32'd0);
        chk("fl_st_ready", 32'(st_ready), 32'd1);
        chk("fl_st_we", 32'(mem_we), 32'd1);
        chk("fl_st_addr", 32'(mem_addr), 32'h0300);
        chk("fl_st_wdata", 32'(mem_wdata), 32'h1234);
        tick();
        st_valid = 1'b0;
        settle();
        chk("fl_only_ld_en", 32'(mem_en), 32'd0);
        tick();
        flush = 1'b0;
        ld_req_valid = 1'b0;
        settle();
        chk("fl_no_resp", 32'(ld_resp_valid), 32'd0);
        idle();
        tick();

        // reset mid-drain with a load response pending
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0050;
        drain_req    = 1'b1;
        st_occupancy = 4'd2;
        tick();
        drain_req    = 1'b0;
        ld_req_valid = 1'b0;
        settle();
        chk("rst_pending_resp", 32'(ld_resp_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        st_occupancy = 4'd0;
        ld_req_valid = 1'b1;
        settle();
        chk("rst_mid_resp", 32'(ld_resp_valid), 32'd0);
        chk("rst_mid_done", 32'(drain_done), 32'd0);
        chk("rst_mid_normal", 32'(ld_req_ready), 32'd1);
        tick();
        chk("rst_mid_no_pulse", 32'(drain_done), 32'd0);
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
